// File: rtl/hc595_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hc595_pkg
// Description : Shared constants for the 74HC595 frame receiver: frame size,
//               bit-counter overrun marker, FSM state encoding and the
//               7-segment code table with its reverse-lookup helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hc595_pkg;

    localparam int FRAME_W     = 16;
    localparam int BIT_CNT_OVR = 17;
    localparam int BIT_CNT_W   = 5;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Segment code (gfedcba) for nibble i lives at SEG_CODE[i].
    localparam logic [15:0][6:0] SEG_CODE = {
        7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
        7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f
    };

    // Reverse lookup: returns {hit, nibble}; hit = 0 for codes outside the table.
    function automatic logic [4:0] seg_decode(input logic [6:0] code);
        logic [4:0] res;
        res = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (SEG_CODE[i] == code) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hc595_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : hc595_sync_edge
// Description : Two-flop synchronizer with registered rising-edge detect.
//               o_level is delayed to line up with o_rise so that a data
//               line sampled through an identical instance is taken at the
//               same instant as the clock line it accompanies.
// Revision    : 1.0 - initial release
// ============================================================================
module hc595_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_level,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_prev;
    logic r_rise;

    // Synchronize the async input and register a one-cycle pulse on each rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_s1   <= i_din;
            r_s2   <= r_s1;
            r_prev <= r_s2;
            r_rise <= r_s2 & ~r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/hc595_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : hc595_frame_rx
// Description : Receive side of the 7-segment 74HC595 serial driver. Rebuilds
//               each 16-bit frame from the ds_data/ds_shcp/ds_stcp stream and
//               decodes segment code plus active-low digit select back into a
//               per-digit hex nibble store.
// Revision    : 1.0 - initial release
// ============================================================================
module hc595_frame_rx
    import hc595_pkg::*;
#(
    parameter int MAX_SMG_NUM = 4,
    parameter int TIMEOUT_CNT = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ds_data,
    input  logic                     ds_shcp,
    input  logic                     ds_stcp,
    output logic [MAX_SMG_NUM*4-1:0] dout,
    output logic [MAX_SMG_NUM-1:0]   dout_vld,
    output logic                     blank,
    output logic                     frame_err
);

    localparam int            c_to_w    = (TIMEOUT_CNT > 2) ? $clog2(TIMEOUT_CNT) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CNT - 1);

    logic w_data_lvl, w_data_rise;
    logic w_shcp_lvl, w_shcp_rise;
    logic w_stcp_lvl, w_stcp_rise;

    logic [0:0]             r_state;
    logic [FRAME_W-1:0]     r_sr;
    logic [BIT_CNT_W-1:0]   r_bit_cnt;
    logic [c_to_w-1:0]      r_to_cnt;
    logic [MAX_SMG_NUM*4-1:0] r_dout;
    logic [MAX_SMG_NUM-1:0] r_dout_vld;
    logic                   r_blank;
    logic                   r_frame_err;

    logic [FRAME_W-1:0]     w_sr_nxt;
    logic [BIT_CNT_W-1:0]   w_cnt_nxt;
    logic [MAX_SMG_NUM-1:0] w_sel_z;
    logic                   w_sel_blank;
    logic                   w_sel_multi;
    logic [4:0]             w_dec;
    logic                   w_unused;

    hc595_sync_edge u_sync_data (
        .clk     (clk),
        .rst     (rst),
        .i_din   (ds_data),
        .o_level (w_data_lvl),
        .o_rise  (w_data_rise)
    );

    hc595_sync_edge u_sync_shcp (
        .clk     (clk),
        .rst     (rst),
        .i_din   (ds_shcp),
        .o_level (w_shcp_lvl),
        .o_rise  (w_shcp_rise)
    );

    hc595_sync_edge u_sync_stcp (
        .clk     (clk),
        .rst     (rst),
        .i_din   (ds_stcp),
        .o_level (w_stcp_lvl),
        .o_rise  (w_stcp_rise)
    );

    // Post-shift view of the frame, so a shift landing with stcp still counts.
    always_comb begin
        w_sr_nxt  = r_sr;
        w_cnt_nxt = r_bit_cnt;
        if (w_shcp_rise) begin
            w_sr_nxt = {r_sr[FRAME_W-2:0], w_data_lvl};
            if (r_state == IDLE) begin
                w_cnt_nxt = BIT_CNT_W'(1);
            end else if (r_bit_cnt == BIT_CNT_W'(BIT_CNT_OVR)) begin
                w_cnt_nxt = r_bit_cnt;
            end else begin
                w_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            end
        end
    end

    // Select is active-low, so its inverse is one-hot for a legal single digit.
    assign w_sel_z     = ~w_sr_nxt[MAX_SMG_NUM-1:0];
    assign w_sel_blank = (w_sel_z == '0);
    assign w_sel_multi = ((w_sel_z & (w_sel_z - MAX_SMG_NUM'(1))) != '0);
    assign w_dec       = seg_decode(w_sr_nxt[14:8]);

    assign w_unused = ^{w_sr_nxt, w_data_rise, w_shcp_lvl, w_stcp_lvl};

    // Frame FSM: shift on shcp, abort on timeout, evaluate on stcp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sr        <= '0;
            r_bit_cnt   <= '0;
            r_to_cnt    <= '0;
            r_dout      <= '0;
            r_dout_vld  <= '0;
            r_blank     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_dout_vld  <= '0;
            r_blank     <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_stcp_rise) begin
                r_state   <= IDLE;
                r_sr      <= w_sr_nxt;
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
                if (w_cnt_nxt != BIT_CNT_W'(FRAME_W)) begin
                    r_frame_err <= 1'b1;
                end else if (w_sel_blank) begin
                    r_blank <= 1'b1;
                end else if (w_sel_multi || !w_dec[4]) begin
                    r_frame_err <= 1'b1;
                end else begin
                    r_dout_vld <= w_sel_z;
                    for (int k = 0; k < MAX_SMG_NUM; k++) begin
                        if (w_sel_z[k]) begin
                            r_dout[4*k +: 4] <= w_dec[3:0];
                        end
                    end
                end
            end else if (w_shcp_rise) begin
                r_state   <= SHIFT;
                r_sr      <= w_sr_nxt;
                r_bit_cnt <= w_cnt_nxt;
                r_to_cnt  <= '0;
            end else if (r_state == SHIFT) begin
                if (r_to_cnt == c_to_last) begin
                    r_frame_err <= 1'b1;
                    r_state     <= IDLE;
                    r_bit_cnt   <= '0;
                    r_to_cnt    <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + c_to_w'(1);
                end
            end
        end
    end

    assign dout      = r_dout;
    assign dout_vld  = r_dout_vld;
    assign blank     = r_blank;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_hc595_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_hc595_frame_rx
// Description : Self-checking bench for hc595_frame_rx. Drives 595-style
//               serial frames and compares against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hc595_frame_rx;

    localparam int N     = 4;
    localparam int TO    = 1000;
    localparam int HALF  = 13;
    localparam int K_VLD = 0;
    localparam int K_BLANK = 1;
    localparam int K_ERR = 2;

    logic clk = 1'b0;
    logic rst;
    logic ds_data;
    logic ds_shcp;
    logic ds_stcp;
    logic [N*4-1:0] dout;
    logic [N-1:0]   dout_vld;
    logic           blank;
    logic           frame_err;

    int n_checks = 0;
    int n_errs   = 0;
    logic [15:0] exp_dout;

    hc595_frame_rx #(.MAX_SMG_NUM(N), .TIMEOUT_CNT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .ds_data   (ds_data),
        .ds_shcp   (ds_shcp),
        .ds_stcp   (ds_stcp),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .blank     (blank),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int n);
        case (n)
            0: return 7'h3f;  1: return 7'h06;  2: return 7'h5b;  3: return 7'h4f;
            4: return 7'h66;  5: return 7'h6d;  6: return 7'h7d;  7: return 7'h07;
            8: return 7'h7f;  9: return 7'h6f; 10: return 7'h77; 11: return 7'h7c;
           12: return 7'h39; 13: return 7'h5e; 14: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Legal frame for one digit with random DP and random don't-care bits.
    function automatic logic [15:0] mk(input int nib, input int dig);
        logic [15:0] v;
        v = {1'($urandom_range(0, 1)), seg_of(nib), 4'($urandom_range(0, 15)), 4'hF};
        v[dig] = 1'b0;
        return v;
    endfunction

    // Frame-level model: outcome of committing v after nbits shifts.
    function automatic void model(input logic [15:0] v, input int nbits,
                                  output int kind, output logic [3:0] vld);
        logic [3:0] z;
        int hit;
        z    = ~v[3:0];
        vld  = 4'b0;
        kind = K_ERR;
        hit  = -1;
        for (int i = 0; i < 16; i++) if (seg_of(i) == v[14:8]) hit = i;
        if (nbits != 16)               kind = K_ERR;
        else if (z == 4'b0)            kind = K_BLANK;
        else if ($countones(z) != 1)   kind = K_ERR;
        else if (hit < 0)              kind = K_ERR;
        else begin
            kind = K_VLD;
            vld  = z;
            for (int k = 0; k < 4; k++) if (z[k]) exp_dout[4*k +: 4] = 4'(hit);
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        ds_data = b;
        ds_shcp = 1'b0;
        tick(HALF);
        ds_shcp = 1'b1;
        tick(HALF);
    endtask

    // MSB first; bits beyond 16 are leading zeros so the last 16 shifted are v.
    task automatic send_frame(input logic [15:0] v, input int nbits);
        logic [31:0] w;
        w = 32'(v);
        for (int i = nbits - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Raise stcp and watch the output pulses over a fixed window.
    task automatic strobe(output int nv, output int nb, output int ne,
                          output int first, output logic [3:0] vs);
        nv = 0; nb = 0; ne = 0; first = -1; vs = 4'b0;
        ds_stcp = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == HALF) ds_stcp = 1'b0;
            if (dout_vld != 4'b0) begin nv++; vs |= dout_vld; if (first < 0) first = i; end
            if (blank)            begin nb++; if (first < 0) first = i; end
            if (frame_err)        begin ne++; if (first < 0) first = i; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ds_data = 1'b0; ds_shcp = 1'b0; ds_stcp = 1'b0;
        exp_dout = 16'h0;
        tick(3);
        n_checks++;
        if (dout !== 16'h0) begin n_errs++; $display("FAIL reset_dout got=%h want=0", dout); end
        n_checks++;
        if (dout_vld !== 4'h0) begin n_errs++; $display("FAIL reset_vld got=%b want=0000", dout_vld); end
        n_checks++;
        if (blank !== 1'b0 || frame_err !== 1'b0) begin
            n_errs++; $display("FAIL reset_pulses got blank=%b err=%b want 0 0", blank, frame_err);
        end
        rst = 1'b0;
        tick(5);
        n_checks++;
        if ({dout, dout_vld, blank, frame_err} !== 22'h0) begin
            n_errs++; $display("FAIL post_reset got dout=%h vld=%b b=%b e=%b want all 0", dout, dout_vld, blank, frame_err);
        end
    endtask

    task automatic test_decode();
        logic [15:0] tv [2];
        int kind, nv, nb, ne, first;
        logic [3:0] evld, vs;
        tv[0] = 16'h3F0E;
        tv[1] = 16'h7C0B;
        for (int t = 0; t < 2; t++) begin
            send_frame(tv[t], 16);
            model(tv[t], 16, kind, evld);
            strobe(nv, nb, ne, first, vs);
            n_checks++;
            if (nv != 1 || nb != 0 || ne != 0) begin
                n_errs++; $display("FAIL decode_pulses frame=%h got vld=%0d blank=%0d err=%0d want 1 0 0", tv[t], nv, nb, ne);
            end
            n_checks++;
            if (vs !== evld) begin n_errs++; $display("FAIL decode_vld frame=%h got=%b want=%b", tv[t], vs, evld); end
            n_checks++;
            if (dout !== exp_dout) begin n_errs++; $display("FAIL decode_dout frame=%h got=%h want=%h", tv[t], dout, exp_dout); end
            n_checks++;
            if (first != 4) begin n_errs++; $display("FAIL decode_latency frame=%h got=%0d want=4", tv[t], first); end
        end
        n_checks++;
        if (dout[11:8] !== 4'hb || dout[3:0] !== 4'h0) begin
            n_errs++; $display("FAIL decode_nibbles got=%h want=0b00 in digits 2,0", dout);
        end
    endtask

    task automatic test_reject();
        logic [15:0] tv [5];
        int tn [5];
        int kind, nv, nb, ne, first;
        logic [3:0] evld, vs;
        tv[0] = 16'h3F0F; tn[0] = 16;
        tv[1] = 16'h3F0C; tn[1] = 16;
        tv[2] = 16'h3F0E; tn[2] = 15;
        tv[3] = 16'h3F0E; tn[3] = 18;
        tv[4] = 16'h000E; tn[4] = 16;
        for (int t = 0; t < 5; t++) begin
            send_frame(tv[t], tn[t]);
            model(tv[t], tn[t], kind, evld);
            strobe(nv, nb, ne, first, vs);
            n_checks++;
            if (nv != 0 || nb != int'(kind == K_BLANK) || ne != int'(kind == K_ERR)) begin
                n_errs++; $display("FAIL reject_pulses frame=%h bits=%0d got vld=%0d blank=%0d err=%0d want kind=%0d",
                                   tv[t], tn[t], nv, nb, ne, kind);
            end
            n_checks++;
            if (dout !== exp_dout) begin n_errs++; $display("FAIL reject_dout frame=%h got=%h want=%h", tv[t], dout, exp_dout); end
        end
    endtask

    task automatic test_timeout();
        logic [15:0] v;
        int at, extra, kind, nv, nb, ne, first;
        logic [3:0] evld, vs;
        v = 16'hA5C3;
        for (int i = 15; i >= 9; i--) send_bit(v[i]);
        ds_data = v[8];
        ds_shcp = 1'b0;
        tick(HALF);
        ds_shcp = 1'b1;
        at = -1;
        extra = 0;
        for (int i = 1; i <= TO + 100; i++) begin
            @(posedge clk);
            #1;
            if (frame_err) begin if (at < 0) at = i; else extra++; end
            if (dout_vld != 4'b0 || blank) extra++;
        end
        n_checks++;
        if (at != TO + 4) begin n_errs++; $display("FAIL timeout_at got=%0d want=%0d", at, TO + 4); end
        n_checks++;
        if (extra != 0) begin n_errs++; $display("FAIL timeout_extra got=%0d want=0", extra); end
        send_frame(16'h6F07, 16);
        model(16'h6F07, 16, kind, evld);
        strobe(nv, nb, ne, first, vs);
        n_checks++;
        if (nv != 1 || nb != 0 || ne != 0 || vs !== 4'b1000) begin
            n_errs++; $display("FAIL timeout_recover got vld=%0d/%b blank=%0d err=%0d want 1/1000 0 0", nv, vs, nb, ne);
        end
        n_checks++;
        if (dout !== exp_dout || dout[15:12] !== 4'h9) begin
            n_errs++; $display("FAIL timeout_dout got=%h want=%h", dout, exp_dout);
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        int nbits, r, kind, nv, nb, ne, first;
        logic [3:0] evld, vs;
        for (int n = 0; n < 20; n++) begin
            r = $urandom_range(0, 9);
            nbits = 16;
            if (r < 6) v = mk($urandom_range(0, 15), $urandom_range(0, 3));
            else if (r < 8) v = 16'($urandom);
            else begin
                v = mk($urandom_range(0, 15), $urandom_range(0, 3));
                case ($urandom_range(0, 2))
                    0: nbits = 15;
                    1: nbits = 17;
                    default: nbits = 0;
                endcase
            end
            send_frame(v, nbits);
            model(v, nbits, kind, evld);
            strobe(nv, nb, ne, first, vs);
            n_checks++;
            if (nv != int'(kind == K_VLD) || nb != int'(kind == K_BLANK) || ne != int'(kind == K_ERR)) begin
                n_errs++; $display("FAIL random_pulses frame=%h bits=%0d got vld=%0d blank=%0d err=%0d want kind=%0d",
                                   v, nbits, nv, nb, ne, kind);
            end
            n_checks++;
            if (vs !== evld) begin n_errs++; $display("FAIL random_vld frame=%h got=%b want=%b", v, vs, evld); end
            n_checks++;
            if (dout !== exp_dout) begin n_errs++; $display("FAIL random_dout frame=%h got=%h want=%h", v, dout, exp_dout); end
        end
    endtask

    task automatic test_loopback_rst();
        logic [15:0] din, v;
        int kind, nv, nb, ne, first;
        logic [3:0] evld, vs;
        din = 16'h1234;
        for (int k = 0; k < 4; k++) begin
            v = {1'b0, seg_of(int'(din[4*k +: 4])), 4'h0, 4'hF};
            v[k] = 1'b0;
            send_frame(v, 16);
            model(v, 16, kind, evld);
            strobe(nv, nb, ne, first, vs);
            n_checks++;
            if (nv != 1 || vs !== evld || nb != 0 || ne != 0) begin
                n_errs++; $display("FAIL loop_frame digit=%0d got vld=%0d/%b want 1/%b", k, nv, vs, evld);
            end
        end
        n_checks++;
        if (dout !== 16'h1234) begin n_errs++; $display("FAIL loop_dout got=%h want=1234", dout); end
        // Reset mid-frame: clear is immediate and asynchronous.
        for (int i = 15; i >= 8; i--) send_bit(v[i]);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dout, dout_vld, blank, frame_err} !== 22'h0) begin
            n_errs++; $display("FAIL rst_mid got dout=%h vld=%b b=%b e=%b want all 0", dout, dout_vld, blank, frame_err);
        end
        exp_dout = 16'h0;
        ds_shcp = 1'b0;
        tick(HALF);
        rst = 1'b0;
        tick(3);
        v = mk(5, 1);
        send_frame(v, 16);
        model(v, 16, kind, evld);
        strobe(nv, nb, ne, first, vs);
        n_checks++;
        if (nv != 1 || nb != 0 || ne != 0 || vs !== 4'b0010) begin
            n_errs++; $display("FAIL rst_recover got vld=%0d/%b blank=%0d err=%0d want 1/0010 0 0", nv, vs, nb, ne);
        end
        n_checks++;
        if (dout !== 16'h0050) begin n_errs++; $display("FAIL rst_recover_dout got=%h want=0050", dout); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_reject();
        test_timeout();
        test_random();
        test_loopback_rst();
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #(20_000_000);
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
